// File: rtl/ahb_slave_regfile_if.sv
// AHB-Lite slave-side signal bundle: the decoder/CPU side drives the
// request signals and HREADY_IN; the register file drives the response.
interface ahb_slave_regfile_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY_IN;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY_IN,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY_IN,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_slave_regfile.sv
// AHB-Lite responder for a bank of REG_NUM word registers, with programmable
// wait states and the two-cycle ERROR response.
module ahb_slave_regfile #(
  parameter int WAIT_STATES  = 1,
  parameter int REG_NUM      = 8,
  parameter int OFFSET_WIDTH = 12,
  localparam int WORD_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ahb_slave_regfile_if.slave            bus,
  output logic [REG_NUM*WORD_WIDTH-1:0] regs_out
);

  localparam int IDX_W = $clog2(REG_NUM);
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [OFFSET_WIDTH-3:0] WORD_LIMIT = (OFFSET_WIDTH-2)'(REG_NUM);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               write_q, write_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               addr_err;
  logic               commit;
  logic               unused_bits;

  assign accept   = bus.HSEL & bus.HTRANS[1] & bus.HREADY_IN;
  assign addr_err = (bus.HADDR[1:0] != 2'b00) ||
                    (bus.HSIZE != 3'b010) ||
                    (bus.HADDR[OFFSET_WIDTH-1:2] >= WORD_LIMIT);
  assign commit   = (state_q == S_DATA) && write_q;

  // Upper address bits are qualified by the decoder; HTRANS[0] (SEQ vs NONSEQ) is irrelevant here.
  assign unused_bits = ^{bus.HADDR[WORD_WIDTH-1:OFFSET_WIDTH], bus.HTRANS[0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 end with HREADY=1, so each may open a new data phase.
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = bus.HADDR[2 +: IDX_W];
          write_d = bus.HWRITE & ~addr_err;
          if (addr_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.HREADY = 1'b1;
    bus.HRESP  = 2'b00;
    bus.HRDATA = '0;
    case (state_q)
      S_WAIT: bus.HREADY = 1'b0;
      S_DATA: begin
        if (!write_q) begin
          bus.HRDATA = regs_out[idx_q*WORD_WIDTH +: WORD_WIDTH];
        end
      end
      S_ERR1: begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 2'b01;
      end
      S_ERR2: bus.HRESP = 2'b01;
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
      logic [WORD_WIDTH-1:0] reg_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          reg_q <= '0;
        end else if (commit && (idx_q == IDX_W'(gi))) begin
          reg_q <= bus.HWDATA;
        end
      end

      assign regs_out[gi*WORD_WIDTH +: WORD_WIDTH] = reg_q;
    end
  endgenerate

endmodule
